// File: rtl/shift_seq_ctrl_pkg.sv
// rtl/shift_seq_ctrl_pkg.sv - shared constants and state encoding for the shift sequencer
// Purpose : state encoding of the sequencer FSM and the shift-register mode codes it drives.
// Ports   : none (package).
package shift_seq_ctrl_pkg;

  localparam int SEQ_WIDTH = 4;  // default register width
  localparam int SEQ_CNT_W = 3;  // default bit-counter width, >= clog2(WIDTH+1)

  // Mode select codes understood by the universal shift register.
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_SHL  = 2'b01;  // shift toward MSB, serial_in_r enters at LSB
  localparam logic [1:0] SR_SHR  = 2'b10;  // shift toward LSB
  localparam logic [1:0] SR_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_TX = 3'd2,
    ST_SHIFT_RX = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// rtl/shift_seq_ctrl_if.sv - command, serial and result handshakes of the shift sequencer
// Purpose : bundles the four handshake channels (cmd, tx, rx, out) of shift_seq_ctrl.
// Modports: master - the host side (issues commands, sinks tx bits, sources rx bits, takes results)
//           slave  - the sequencer side
interface shift_seq_ctrl_if
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_rx;
  logic [WIDTH-1:0] cmd_data;
  logic             tx_bit;
  logic             tx_valid;
  logic             tx_ready;
  logic             rx_bit;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output cmd_valid, cmd_rx, cmd_data, tx_ready, rx_bit, rx_valid, out_ready,
    input  cmd_ready, tx_bit, tx_valid, rx_ready, out_data, out_valid
  );

  modport slave (
    input  cmd_valid, cmd_rx, cmd_data, tx_ready, rx_bit, rx_valid, out_ready,
    output cmd_ready, tx_bit, tx_valid, rx_ready, out_data, out_valid
  );

endinterface

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - sequencer driving a universal shift register for serial TX/RX
// Purpose : TX op loads a word into the shift register and serialises it MSB-first;
//           RX op shifts WIDTH bits in and presents the assembled word.
// Ports   : i_clk              clock, rising edge
//           i_clear            synchronous active-high reset
//           io_bus             cmd/tx/rx/out handshakes (slave side)
//           o_busy             high whenever the FSM is not idle
//           o_sr_s             shift register mode select
//           o_sr_parallel_in   shift register parallel load data
//           o_sr_serial_in_r   shift register serial input (enters at LSB)
//           o_sr_clear_b       shift register active-low clear (combinational ~i_clear)
//           i_sr_parallel_out  shift register contents
//           i_sr_serial_out    shift register MSB
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int CNT_W = SEQ_CNT_W
) (
  input  logic                 i_clk,
  input  logic                 i_clear,
  shift_seq_ctrl_if.slave      io_bus,
  output logic                 o_busy,
  output logic [1:0]           o_sr_s,
  output logic [WIDTH-1:0]     o_sr_parallel_in,
  output logic                 o_sr_serial_in_r,
  output logic                 o_sr_clear_b,
  input  logic [WIDTH-1:0]     i_sr_parallel_out,
  input  logic                 i_sr_serial_out
);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_last;
  logic [WIDTH-1:0]   r_word;
  logic [WIDTH-1:0]   w_word_next;

  logic               w_cmd_ready;
  logic               w_tx_valid;
  logic               w_tx_bit;
  logic               w_rx_ready;
  logic               w_out_valid;
  logic [WIDTH-1:0]   w_out_data;
  logic [1:0]         w_sr_s;
  logic [WIDTH-1:0]   w_sr_pin;
  logic               w_sr_sin;

  // Counter saturates at WIDTH so a stray extra beat can never wrap it.
  assign w_cnt_inc = (r_cnt == CNT_W'(WIDTH)) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_word  <= w_word_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_word_next = r_word;
    w_cmd_ready = 1'b0;
    w_tx_valid  = 1'b0;
    w_tx_bit    = 1'b0;
    w_rx_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_data  = '0;
    w_sr_s      = SR_HOLD;
    w_sr_pin    = '0;
    w_sr_sin    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_cmd_ready = 1'b1;
        if (io_bus.cmd_valid) begin
          if (io_bus.cmd_rx) begin
            w_cnt_next = '0;
            w_next     = ST_SHIFT_RX;
          end else begin
            w_word_next = io_bus.cmd_data;
            w_next      = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        w_sr_s     = SR_LOAD;
        w_sr_pin   = r_word;
        w_cnt_next = '0;
        w_next     = ST_SHIFT_TX;
      end

      // The register MSB is the current bit; each accepted beat shifts the
      // next bit into the MSB and back-fills zeros.
      ST_SHIFT_TX: begin
        w_tx_valid = 1'b1;
        w_tx_bit   = i_sr_serial_out;
        if (io_bus.tx_ready) begin
          w_sr_s     = SR_SHL;
          w_cnt_next = w_cnt_inc;
          if (w_last) begin
            w_next = ST_IDLE;
          end
        end
      end

      // Bits enter at the LSB and move up, so the first bit lands in the MSB.
      ST_SHIFT_RX: begin
        w_rx_ready = 1'b1;
        w_sr_sin   = io_bus.rx_bit;
        if (io_bus.rx_valid) begin
          w_sr_s     = SR_SHL;
          w_cnt_next = w_cnt_inc;
          if (w_last) begin
            w_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        w_out_valid = 1'b1;
        w_out_data  = i_sr_parallel_out;
        if (io_bus.out_ready) begin
          w_next = ST_IDLE;
        end
      end

      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // While clear is asserted every output is forced low so nothing partial
  // escapes during an abort; the register itself is zeroed through clear_b.
  assign io_bus.cmd_ready  = w_cmd_ready & ~i_clear;
  assign io_bus.tx_valid   = w_tx_valid & ~i_clear;
  assign io_bus.tx_bit     = w_tx_bit & ~i_clear;
  assign io_bus.rx_ready   = w_rx_ready & ~i_clear;
  assign io_bus.out_valid  = w_out_valid & ~i_clear;
  assign io_bus.out_data   = w_out_data & {WIDTH{~i_clear}};
  assign o_busy            = (r_state != ST_IDLE) & ~i_clear;
  assign o_sr_s            = w_sr_s & {2{~i_clear}};
  assign o_sr_parallel_in  = w_sr_pin & {WIDTH{~i_clear}};
  assign o_sr_serial_in_r  = w_sr_sin & ~i_clear;
  assign o_sr_clear_b      = ~i_clear;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl paired with a shift register
module tb_shift_seq_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         clear;
  logic         busy;
  logic [1:0]   sr_s;
  logic [W-1:0] sr_parallel_in;
  logic         sr_serial_in_r;
  logic         sr_clear_b;
  logic [W-1:0] sr_q;
  logic         sr_serial_out;

  int checks = 0;
  int errors = 0;

  shift_seq_ctrl_if #(.WIDTH(W)) bus ();

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
    .i_clk             (clk),
    .i_clear           (clear),
    .io_bus            (bus),
    .o_busy            (busy),
    .o_sr_s            (sr_s),
    .o_sr_parallel_in  (sr_parallel_in),
    .o_sr_serial_in_r  (sr_serial_in_r),
    .o_sr_clear_b      (sr_clear_b),
    .i_sr_parallel_out (sr_q),
    .i_sr_serial_out   (sr_serial_out)
  );

  // 4-bit universal shift register partner
  always_ff @(posedge clk) begin
    if (!sr_clear_b) begin
      sr_q <= '0;
    end else begin
      case (sr_s)
        2'b01:   sr_q <= {sr_q[W-2:0], sr_serial_in_r};
        2'b10:   sr_q <= {1'b0, sr_q[W-1:1]};
        2'b11:   sr_q <= sr_parallel_in;
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign sr_serial_out = sr_q[W-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: bit k of a TX word leaves first-MSB, i.e. floor(w / 2^(W-1-k)) mod 2.
  function automatic int tx_bit_of(input int w, input int k);
    return (w / (1 << (W - 1 - k))) % 2;
  endfunction

  // Reference: RX word has the first received bit at the top position.
  function automatic int rx_word_of(input int b[W]);
    int acc = 0;
    for (int i = 0; i < W; i++) acc += b[i] * (1 << (W - 1 - i));
    return acc;
  endfunction

  // mode 0: always ready, 1: alternate 1,0,1,0..., 2: random
  task automatic run_tx(input logic [W-1:0] w, input int mode);
    int k = 0;
    int cyc = 0;
    logic rdy;
    chk("tx_idle_cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_rx    = 1'b0;
    bus.cmd_data  = w;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    chk("tx_load_sr_s", sr_s, 3);
    chk("tx_load_pin", sr_parallel_in, w);
    chk("tx_load_tx_valid", bus.tx_valid, 0);
    chk("tx_load_busy", busy, 1);
    chk("tx_load_cmd_ready", bus.cmd_ready, 0);
    while (k < W && cyc < 64) begin
      @(negedge clk);
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 2 == 0);
      else rdy = 1'($urandom_range(0, 1));
      bus.tx_ready = rdy;
      #1;
      chk("tx_valid", bus.tx_valid, 1);
      chk("tx_bit", bus.tx_bit, tx_bit_of(int'(w), k));
      chk("tx_sr_s", sr_s, rdy ? 1 : 0);
      chk("tx_busy_cmd_ready", bus.cmd_ready, 0);
      if (rdy) k++;
      cyc++;
    end
    chk("tx_beats", k, W);
    @(negedge clk);
    bus.tx_ready = 1'b0;
    #1;
    chk("tx_end_busy", busy, 0);
    chk("tx_end_tx_valid", bus.tx_valid, 0);
    chk("tx_end_cmd_ready", bus.cmd_ready, 1);
  endtask

  // gaps 0: rx_valid always, 1: fixed gap pattern, 2: random; hold keeps cmd_valid high throughout
  task automatic run_rx(input int b[W], input int gaps, input bit hold);
    int k = 0;
    int cyc = 0;
    int exp_word;
    int wait_n;
    logic v;
    bus.cmd_valid = 1'b1;
    bus.cmd_rx    = 1'b1;
    bus.cmd_data  = W'($urandom);
    @(negedge clk);
    if (!hold) bus.cmd_valid = 1'b0;
    #1;
    chk("rx_start_busy", busy, 1);
    while (k < W && cyc < 64) begin
      if (gaps == 0) v = 1'b1;
      else if (gaps == 1) v = (cyc % 3 != 1);
      else v = 1'($urandom_range(0, 1));
      bus.rx_valid = v;
      bus.rx_bit   = v ? 1'(b[k]) : 1'($urandom_range(0, 1));
      #1;
      chk("rx_ready", bus.rx_ready, 1);
      chk("rx_serial_in", sr_serial_in_r, bus.rx_bit);
      chk("rx_sr_s", sr_s, v ? 1 : 0);
      chk("rx_out_valid_early", bus.out_valid, 0);
      chk("rx_cmd_ready", bus.cmd_ready, 0);
      if (v) k++;
      cyc++;
      @(negedge clk);
    end
    chk("rx_beats", k, W);
    bus.rx_valid = 1'b0;
    exp_word = rx_word_of(b);
    #1;
    chk("rx_done_valid", bus.out_valid, 1);
    chk("rx_done_data", bus.out_data, exp_word);
    chk("rx_done_rx_ready", bus.rx_ready, 0);
    chk("rx_done_sr_s", sr_s, 0);
    wait_n = $urandom_range(1, 3);
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      #1;
      chk("rx_hold_valid", bus.out_valid, 1);
      chk("rx_hold_data", bus.out_data, exp_word);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    chk("rx_end_valid", bus.out_valid, 0);
    chk("rx_end_busy", busy, 0);
    chk("rx_end_cmd_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    int bits[W];
    logic [W-1:0] w;

    clear         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_rx    = 1'b0;
    bus.cmd_data  = '0;
    bus.tx_ready  = 1'b0;
    bus.rx_bit    = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_rx_ready", bus.rx_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sr_s", sr_s, 0);
    chk("rst_sr_clear_b", sr_clear_b, 0);
    chk("rst_sr_q", sr_q, 0);
    clear = 1'b0;
    #1;
    chk("rst_rel_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rel_clear_b", sr_clear_b, 1);

    // 1. TX 1011, always ready
    run_tx(4'b1011, 0);

    // 2. TX 0110, ready alternating
    run_tx(4'b0110, 1);

    // 3. RX 1,1,0,1 with gaps
    bits = '{1, 1, 0, 1};
    run_rx(bits, 1, 1'b0);

    // 4. clear on the 2nd SHIFT_TX beat
    bus.cmd_valid = 1'b1;
    bus.cmd_rx    = 1'b0;
    bus.cmd_data  = 4'b1001;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    bus.tx_ready = 1'b1;
    #1;
    chk("clr_beat1_bit", bus.tx_bit, 1);
    @(negedge clk);
    clear = 1'b1;
    #1;
    chk("clr_during_tx_valid", bus.tx_valid, 0);
    chk("clr_during_clear_b", sr_clear_b, 0);
    @(negedge clk);
    clear = 1'b0;
    bus.tx_ready = 1'b0;
    #1;
    chk("clr_after_busy", busy, 0);
    chk("clr_after_tx_valid", bus.tx_valid, 0);
    chk("clr_after_sr_q", sr_q, 0);
    chk("clr_after_cmd_ready", bus.cmd_ready, 1);

    // 5. cmd_valid held through an RX, second command taken right after IDLE
    for (int i = 0; i < W; i++) bits[i] = $urandom_range(0, 1);
    run_rx(bits, 2, 1'b1);
    for (int i = 0; i < W; i++) bits[i] = $urandom_range(0, 1);
    run_rx(bits, 0, 1'b0);

    // randomized mix
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        w = W'($urandom);
        run_tx(w, 2);
      end else begin
        for (int i = 0; i < W; i++) bits[i] = $urandom_range(0, 1);
        run_rx(bits, 2, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
